// File: rtl/booth_mult.sv
// booth_mult -- sequential signed multiplier, radix-2 Booth.
// Operands are captured on start. Each enabled cycle then performs one
// add/subtract followed by an arithmetic shift right. After WIDTH steps the
// 2*WIDTH-bit two's-complement product is available.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         load operands, clear accumulator and step counter (wins over enable)
//   enable        step strobe; one Booth step per cycle while busy
//   multiplicand  signed operand M, sampled only on start
//   multiplier    signed operand Q, sampled only on start
//   product       {A[WIDTH-1:0], Q}; valid when done=1
//   busy          high from load until the final step completes
//   done          high once WIDTH steps are complete; held until start/reset
module booth_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               enable,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH:0]   m;
  logic [CW-1:0]    cnt;

  logic             step;
  logic [WIDTH:0]   t;

  assign step = (state == S_RUN) && enable && !start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_RUN;
    end else if (step && (cnt == CNT_LAST)) begin
      state_nxt = S_DONE;
    end
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Booth recoding of {Q[0], Qm1}: 01 adds M, 10 subtracts M, else pass A.
  // A and M carry one extra sign bit so M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    t = a;
    case ({q[0], qm1})
      2'b01:   t = a + m;
      2'b10:   t = a - m;
      default: t = a;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      q   <= '0;
      qm1 <= 1'b0;
      m   <= '0;
      cnt <= '0;
    end else if (start) begin
      a   <= '0;
      q   <= multiplier;
      qm1 <= 1'b0;
      m   <= {multiplicand[WIDTH-1], multiplicand};
      cnt <= '0;
    end else if (step) begin
      // Arithmetic shift right of {T, Q, Qm1} by one.
      a   <= {t[WIDTH], t[WIDTH:1]};
      q   <= {t[0], q[WIDTH-1:1]};
      qm1 <= q[0];
      cnt <= cnt + 1'b1;
    end
  end

  assign product = {a[WIDTH-1:0], q};

endmodule

// File: tb/tb_booth_mult.sv
// Directed self-checking bench for booth_mult (WIDTH=8).
module tb_booth_mult;

  localparam int unsigned W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             enable;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic [2*W-1:0]   product;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_bad;

  booth_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .enable       (enable),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, summary not reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] mv, input logic [W-1:0] qv);
    multiplicand = mv;
    multiplier   = qv;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = ~mv;   // operands must be ignored after the load edge
    multiplier   = ~qv;
  endtask

  // Full operation with enable held high; checks done timing and result.
  task automatic run_op(input string tag, input logic [W-1:0] mv,
                        input logic [W-1:0] qv, input logic [15:0] exp);
    load(mv, qv);
    check({tag, " busy after load"}, 32'(busy), 32'd1);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check({tag, " done before 8th step"}, 32'(done), 32'd0);
    tick();
    enable = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    check({tag, " product"}, 32'(product), 32'(exp));
  endtask

  initial begin
    logic [15:0] prev;
    int steps;
    int cyc;

    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    enable       = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Reset state
    #12;
    check("reset product", 32'(product), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: 7*3, including the first intermediate step (A-M then shift)
    load(8'd7, 8'd3);
    enable = 1'b1;
    tick();
    check("t1 first step product", 32'(product), 32'h0000_FC81);
    for (int i = 0; i < 6; i++) tick();
    check("t1 done before 8th", 32'(done), 32'd0);
    tick();
    enable = 1'b0;
    check("t1 done", 32'(done), 32'd1);
    check("t1 busy", 32'(busy), 32'd0);
    check("t1 product", 32'(product), 32'h0000_0015);

    // 2: signed cases
    run_op("t2 -5*3", 8'hFB, 8'd3, 16'hFFF1);
    run_op("t2 3*-5", 8'd3, 8'hFB, 16'hFFF1);
    run_op("t2 0*-128", 8'h00, 8'h80, 16'h0000);

    // 3: corners
    run_op("t3 -128*-128", 8'h80, 8'h80, 16'h4000);
    run_op("t3 -128*127", 8'h80, 8'h7F, 16'hC080);
    run_op("t3 -1*-1", 8'hFF, 8'hFF, 16'h0001);
    run_op("t3 127*127", 8'h7F, 8'h7F, 16'h3F01);

    // 4: enable pattern 1,0,0 repeating
    load(8'd7, 8'd3);
    steps = 0;
    cyc   = 0;
    while (steps < 8 && cyc < 40) begin
      enable = (cyc % 3 == 0);
      prev   = product;
      tick();
      if (enable) begin
        steps++;
        if (steps < 8) check("t4 done early", 32'(done), 32'd0);
      end else begin
        check("t4 frozen product", 32'(product), 32'(prev));
        check("t4 paused busy", 32'(busy), 32'd1);
      end
      cyc++;
    end
    enable = 1'b0;
    check("t4 enabled steps", 32'(steps), 32'd8);
    check("t4 done", 32'(done), 32'd1);
    check("t4 product", 32'(product), 32'h0000_0015);

    // 5: enable after done has no effect; then restart
    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    check("t5 product held", 32'(product), 32'h0000_0015);
    check("t5 done held", 32'(done), 32'd1);
    load(8'd2, 8'd2);
    check("t5 done cleared", 32'(done), 32'd0);
    enable = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    enable = 1'b0;
    check("t5 done", 32'(done), 32'd1);
    check("t5 product", 32'(product), 32'h0000_0004);

    // 6a: asynchronous reset mid-operation
    load(8'd7, 8'd3);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 reset product", 32'(product), 32'd0);
    check("t6 reset busy", 32'(busy), 32'd0);
    check("t6 reset done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6 idle after reset done", 32'(done), 32'd0);
    check("t6 idle after reset busy", 32'(busy), 32'd0);
    enable = 1'b0;

    // 6b: start while busy aborts and reloads
    load(8'd5, 8'd5);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    load(8'hFF, 8'd9);
    check("t6 reload busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) tick();
    check("t6 done before 8th", 32'(done), 32'd0);
    tick();
    enable = 1'b0;
    check("t6 done", 32'(done), 32'd1);
    check("t6 product", 32'(product), 32'h0000_FFF7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
